// File: rtl/mtr_pkg.sv
// Shared types and default constants for the stepper step generator.
package mtr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RAMP  = 3'd2,
    RUN   = 3'd3,
    STOP  = 3'd4
  } mtr_state_t;

  localparam int DEF_CLK_DIV      = 100;
  localparam int DEF_START_PERIOD = 1000;
  localparam int DEF_RAMP_STEP    = 8;
  localparam int DEF_PULSE_W      = 10;
  localparam int DEF_DIR_SETUP    = 50;
  localparam int POS_W            = 32;
  localparam int PERIOD_W         = 16;

endpackage

// File: rtl/mtr_step_gen_tick_prescaler.sv
// Free-running bus_clk divider; tick is a one-cycle pulse on each wrap.
module tick_prescaler #(
  parameter int CLK_DIV = 100
) (
  input  logic bus_clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/mtr_step_gen.sv
// Step/dir/enable generator with linear period ramping, direction setup delay
// and a signed step position counter.
module mtr_step_gen
  import mtr_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int START_PERIOD = DEF_START_PERIOD,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int PULSE_W      = DEF_PULSE_W,
  parameter int DIR_SETUP    = DEF_DIR_SETUP
) (
  input  logic                    bus_clk,
  input  logic                    rst,
  input  logic                    mtr_en,
  input  logic                    mtr_dir,
  input  logic [PERIOD_W-1:0]     mtr_speed,
  input  logic                    pos_clr,
  output logic                    step,
  output logic                    dir,
  output logic                    drv_en,
  output logic                    busy,
  output logic signed [POS_W-1:0] position
);

  localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] RSTEP      = PERIOD_W'(RAMP_STEP);
  localparam logic [PERIOD_W-1:0] SETUP_LAST = PERIOD_W'(DIR_SETUP - 1);
  localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_W - 1);

  // Move cur toward tgt by at most RSTEP, landing exactly on tgt.
  function automatic logic [PERIOD_W-1:0] ramp_toward(input logic [PERIOD_W-1:0] cur,
                                                      input logic [PERIOD_W-1:0] tgt);
    logic [PERIOD_W-1:0] res;
    if (cur > tgt) begin
      res = ((cur - tgt) > RSTEP) ? (cur - RSTEP) : tgt;
    end else if (cur < tgt) begin
      res = ((tgt - cur) > RSTEP) ? (cur + RSTEP) : tgt;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  function automatic logic [PERIOD_W-1:0] stop_inc(input logic [PERIOD_W-1:0] cur);
    logic [PERIOD_W:0] sum;
    sum = {1'b0, cur} + {1'b0, RSTEP};
    return (sum >= {1'b0, START_P}) ? START_P : sum[PERIOD_W-1:0];
  endfunction

  mtr_state_t          state_q, state_d;
  logic                tick;
  logic [PERIOD_W-1:0] per_cnt, cur_period, per_next, setup_cnt, pulse_cnt, tgt;
  logic                last_q, last_set, latch_dir, load_ramp;
  logic                go, stop_req, stepping, stopping, emit;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .bus_clk (bus_clk),
    .rst     (rst),
    .tick    (tick)
  );

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    per_next  = cur_period;
    last_set  = 1'b0;
    latch_dir = 1'b0;
    tgt       = (mtr_speed > START_P) ? START_P : mtr_speed;
    if (tgt == '0) begin
      tgt = PERIOD_W'(1);
    end
    go        = mtr_en && (mtr_speed != '0);
    stop_req  = !mtr_en || (mtr_speed == '0) || (mtr_dir != dir);
    stepping  = (state_q == RAMP) || (state_q == RUN) || (state_q == STOP);
    emit      = stepping && !last_q && (per_cnt == cur_period);
    stopping  = (state_q == STOP) || (((state_q == RAMP) || (state_q == RUN)) && stop_req);

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = SETUP;
          latch_dir = 1'b1;
        end
      end
      SETUP: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (setup_cnt == SETUP_LAST) begin
          state_d = RAMP;
        end
      end
      RAMP, RUN: begin
        if (stop_req) begin
          state_d = STOP;
        end else if (emit) begin
          per_next = ramp_toward(cur_period, tgt);
          state_d  = (per_next == tgt) ? RUN : RAMP;
        end
      end
      STOP: begin
        if (last_q && step && (pulse_cnt == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Deceleration applies to the step that ends the period already in flight.
    if (stopping && emit) begin
      if (cur_period == START_P) begin
        last_set = 1'b1;
      end else begin
        per_next = stop_inc(cur_period);
      end
    end

    load_ramp = (state_q == SETUP) && (state_d == RAMP);
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      dir        <= 1'b0;
      drv_en     <= 1'b0;
      step       <= 1'b0;
      position   <= '0;
      cur_period <= START_P;
      per_cnt    <= '0;
      setup_cnt  <= '0;
      pulse_cnt  <= '0;
      last_q     <= 1'b0;
    end else begin
      if (latch_dir) begin
        dir <= mtr_dir;
      end
      drv_en     <= (state_d == IDLE) ? mtr_en : 1'b1;
      setup_cnt  <= (state_q == SETUP) ? (setup_cnt + PERIOD_W'(1)) : '0;
      cur_period <= load_ramp ? START_P : per_next;

      if (!stepping || emit) begin
        per_cnt <= '0;
      end else if (tick) begin
        per_cnt <= per_cnt + PERIOD_W'(1);
      end

      if (state_d == IDLE) begin
        last_q <= 1'b0;
      end else if (last_set) begin
        last_q <= 1'b1;
      end

      if (emit) begin
        step      <= 1'b1;
        pulse_cnt <= PULSE_LAST;
      end else if (step) begin
        if (pulse_cnt == '0) begin
          step <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt - PERIOD_W'(1);
        end
      end

      // A clear coincident with a step counts that step from zero.
      if (pos_clr && emit) begin
        position <= dir ? 32'sd1 : -32'sd1;
      end else if (pos_clr) begin
        position <= '0;
      end else if (emit) begin
        position <= dir ? (position + 32'sd1) : (position - 32'sd1);
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mtr_step_gen.sv
// Scoreboard bench for mtr_step_gen: expected step events are queued by the
// stimulus and matched by a monitor on every step rising edge.
module tb_mtr_step_gen;

  localparam int CLK_DIV = 4;
  localparam int PULSE_W = 2;

  logic               bus_clk = 1'b0;
  logic               rst;
  logic               mtr_en, mtr_dir, pos_clr;
  logic [15:0]        mtr_speed;
  logic               step, dir, drv_en, busy;
  logic signed [31:0] position;

  typedef struct {
    int   interval;
    int   pos;
    logic d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   hi_cnt = 0;
  logic prev_step = 1'b0;

  mtr_step_gen #(
    .CLK_DIV(CLK_DIV), .START_PERIOD(20), .RAMP_STEP(4), .PULSE_W(PULSE_W), .DIR_SETUP(3)
  ) dut (
    .bus_clk(bus_clk), .rst(rst), .mtr_en(mtr_en), .mtr_dir(mtr_dir),
    .mtr_speed(mtr_speed), .pos_clr(pos_clr), .step(step), .dir(dir),
    .drv_en(drv_en), .busy(busy), .position(position)
  );

  always #5 bus_clk = ~bus_clk;
  always @(posedge bus_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int interval, input int pos, input logic d);
    exp_t e;
    e.interval = interval;
    e.pos      = pos;
    e.d        = d;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge bus_clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every rising step edge pops one expectation.
  always @(negedge bus_clk) begin
    exp_t e;
    if (rst) begin
      prev_step = 1'b0;
      hi_cnt    = 0;
    end else begin
      if (step && !prev_step) begin
        if (sb.size() == 0) begin
          chk("unexpected_step_pos", position, -999999);
        end else begin
          e = sb.pop_front();
          chk("step_position", position, e.pos);
          chk("step_dir", dir, e.d);
          if (e.interval >= 0) chk("step_interval", cyc - last_rise, e.interval);
        end
        last_rise = cyc;
        hi_cnt    = 1;
      end else if (step) begin
        hi_cnt++;
      end else if (prev_step) begin
        chk("pulse_width", hi_cnt, PULSE_W);
      end
      prev_step = step;
    end
  end

  initial begin
    int n;
    rst = 1'b1; mtr_en = 1'b0; mtr_dir = 1'b0; mtr_speed = 16'd0; pos_clr = 1'b0;
    repeat (3) @(negedge bus_clk);
    chk("rst_step", step, 0);
    chk("rst_drv_en", drv_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_position", position, 0);
    rst = 1'b0;
    repeat (5) @(negedge bus_clk);

    // Accelerate to 8 ticks: 20,16,12,8,8...
    push(-1, 1, 1); push(64, 2, 1); push(48, 3, 1); push(32, 4, 1); push(32, 5, 1); push(32, 6, 1);
    mtr_en = 1'b1; mtr_dir = 1'b1; mtr_speed = 16'd8;
    repeat (2) @(negedge bus_clk);
    chk("go_dir", dir, 1);
    chk("go_busy", busy, 1);
    chk("go_drv_en", drv_en, 1);
    wait_drain(2000);

    // Slow down to 16, then back to 8.
    push(32, 7, 1); push(48, 8, 1); push(64, 9, 1); push(64, 10, 1); push(64, 11, 1);
    mtr_speed = 16'd16;
    wait_drain(2000);
    push(64, 12, 1); push(48, 13, 1); push(32, 14, 1); push(32, 15, 1);
    mtr_speed = 16'd8;
    wait_drain(2000);

    // Disable: 8,12,16,20 then idle.
    push(32, 16, 1); push(48, 17, 1); push(64, 18, 1); push(80, 19, 1);
    mtr_en = 1'b0;
    wait_drain(2000);
    repeat (5) @(negedge bus_clk);
    chk("stop_busy", busy, 0);
    chk("stop_drv_en", drv_en, 0);
    repeat (200) @(negedge bus_clk);
    chk("stop_position", position, 19);

    // Restart, then reverse direction through a full stop.
    push(-1, 20, 1); push(64, 21, 1); push(48, 22, 1); push(32, 23, 1);
    mtr_en = 1'b1; mtr_speed = 16'd8;
    wait_drain(2000);
    push(32, 24, 1); push(48, 25, 1); push(64, 26, 1); push(80, 27, 1);
    push(-1, 26, 0); push(64, 25, 0); push(48, 24, 0); push(32, 23, 0);
    mtr_dir = 1'b0;
    wait_drain(4000);
    chk("rev_dir", dir, 0);

    // Asynchronous reset while the pulse is high.
    chk("pre_rst_step", step, 1);
    mtr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_step", step, 0);
    chk("async_drv_en", drv_en, 0);
    chk("async_busy", busy, 0);
    chk("async_position", position, 0);
    @(negedge bus_clk);
    rst = 1'b0;
    repeat (3) @(negedge bus_clk);
    chk("post_rst_busy", busy, 0);

    // Enabled at speed 0: driver on, no motion.
    mtr_en = 1'b1; mtr_dir = 1'b1; mtr_speed = 16'd0;
    repeat (50) @(negedge bus_clk);
    chk("spd0_drv_en", drv_en, 1);
    chk("spd0_busy", busy, 0);

    // Speed above the start period is clamped to it.
    push(-1, 1, 1); push(80, 2, 1); push(80, 3, 1);
    mtr_speed = 16'd50;
    wait_drain(2000);

    // Clear coincident with the next step rise.
    push(80, 1, 1); push(80, 2, 1);
    n = 0;
    while (cyc != last_rise + 79 && n < 200) begin
      @(negedge bus_clk);
      n++;
    end
    chk("clr_align", cyc - last_rise, 79);
    pos_clr = 1'b1;
    @(negedge bus_clk);
    pos_clr = 1'b0;
    wait_drain(2000);

    // Stop from the start period: one more step then idle.
    push(80, 3, 1);
    mtr_en = 1'b0;
    wait_drain(2000);
    repeat (10) @(negedge bus_clk);
    chk("final_busy", busy, 0);
    chk("final_drv_en", drv_en, 0);
    repeat (150) @(negedge bus_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
